// File: rtl/filter_cfg_ctrl.sv
// filter_cfg_ctrl: serial configuration sequencer for filter_unit.
// A block write fetches NTAPS words from the host, shifts each one MSB-first
// over sde/sd and finishes with an upload pulse. A block read issues a
// download pulse, shifts NTAPS words back in from the filter and hands them
// to the host one at a time.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid_in/cmd_ready_out       host command handshake, cmd_op_in 0=wr 1=rd
//   wr_data_in/wr_valid_in/wr_ready_out   write word stream from host
//   rd_data_out/rd_valid_out/rd_ready_in  read word stream to host
//   busy_out, done_out               status, done is a one-cycle pulse
//   sde_out, sd_out, sd_in           serial enable / data to and from filter
//   ul_out, dl_out                   upload / download pulses to filter
module filter_cfg_ctrl #(
  parameter int unsigned DATABITS = 16,
  parameter int unsigned NTAPS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic                cmd_op_in,
  input  logic [DATABITS-1:0] wr_data_in,
  input  logic                wr_valid_in,
  output logic                wr_ready_out,
  output logic [DATABITS-1:0] rd_data_out,
  output logic                rd_valid_out,
  input  logic                rd_ready_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                sde_out,
  output logic                sd_out,
  input  logic                sd_in,
  output logic                ul_out,
  output logic                dl_out
);

  localparam int unsigned BW = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam int unsigned WW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATABITS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NTAPS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_FETCH, WR_SHIFT, UL, DL, RD_SHIFT, RD_HOLD, DONE
  } state_t;

  // Per-state output flags, registered together with the state.
  typedef struct packed {
    logic cmd_ready;
    logic wr_ready;
    logic rd_valid;
    logic busy;
    logic done;
    logic sde;
    logic ul;
    logic dl;
  } outs_t;

  // Output flags that hold while the FSM sits in state s.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      IDLE:               o.cmd_ready = 1'b1;
      WR_FETCH:           o.wr_ready  = 1'b1;
      WR_SHIFT, RD_SHIFT: o.sde       = 1'b1;
      UL:                 o.ul        = 1'b1;
      DL:                 o.dl        = 1'b1;
      RD_HOLD:            o.rd_valid  = 1'b1;
      DONE:               o.done      = 1'b1;
      default:            o.busy      = 1'b0;
    endcase
    return o;
  endfunction

  state_t              state;
  outs_t               outs;
  logic [BW-1:0]       bit_cnt;
  logic [WW-1:0]       word_cnt;
  logic [DATABITS-1:0] shreg;
  logic [DATABITS-1:0] shl;
  logic [DATABITS-1:0] shin;

  // shl drives the next write bit; shin is the read word with sd_in appended.
  assign shl  = shreg << 1;
  assign shin = shl | DATABITS'(sd_in);

  assign cmd_ready_out = outs.cmd_ready;
  assign wr_ready_out  = outs.wr_ready;
  assign rd_valid_out  = outs.rd_valid;
  assign busy_out      = outs.busy;
  assign done_out      = outs.done;
  assign sde_out       = outs.sde;
  assign ul_out        = outs.ul;
  assign dl_out        = outs.dl;

  // Sequencer FSM; every output register is loaded with the value for the
  // state being entered so ports change exactly on the state boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outs        <= decode(IDLE);
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shreg       <= '0;
      sd_out      <= 1'b0;
      rd_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_in) begin
            word_cnt <= '0;
            if (cmd_op_in) begin
              state <= DL;
              outs  <= decode(DL);
            end else begin
              state <= WR_FETCH;
              outs  <= decode(WR_FETCH);
            end
          end
        end
        WR_FETCH: begin
          if (wr_valid_in) begin
            shreg   <= wr_data_in;
            sd_out  <= wr_data_in[DATABITS-1];
            bit_cnt <= '0;
            state   <= WR_SHIFT;
            outs    <= decode(WR_SHIFT);
          end
        end
        WR_SHIFT: begin
          shreg <= shl;
          if (bit_cnt == BIT_LAST) begin
            sd_out <= 1'b0;
            if (word_cnt == WORD_LAST) begin
              state <= UL;
              outs  <= decode(UL);
            end else begin
              word_cnt <= word_cnt + WW'(1);
              state    <= WR_FETCH;
              outs     <= decode(WR_FETCH);
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            sd_out  <= shl[DATABITS-1];
          end
        end
        UL: begin
          state <= DONE;
          outs  <= decode(DONE);
        end
        DL: begin
          bit_cnt <= '0;
          state   <= RD_SHIFT;
          outs    <= decode(RD_SHIFT);
        end
        RD_SHIFT: begin
          shreg <= shin;
          if (bit_cnt == BIT_LAST) begin
            rd_data_out <= shin;
            state       <= RD_HOLD;
            outs        <= decode(RD_HOLD);
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        RD_HOLD: begin
          if (rd_ready_in) begin
            if (word_cnt == WORD_LAST) begin
              state <= DONE;
              outs  <= decode(DONE);
            end else begin
              word_cnt <= word_cnt + WW'(1);
              bit_cnt  <= '0;
              state    <= RD_SHIFT;
              outs     <= decode(RD_SHIFT);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          outs  <= decode(IDLE);
        end
        default: begin
          state <= IDLE;
          outs  <= decode(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// Testbench for filter_cfg_ctrl: a behavioural filter_unit serial model sits
// on the configuration port; host traffic uses random coefficient blocks and
// results are checked against word lists, bit streams and cycle formulas.
module tb_filter_cfg_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned SL = DW + 1;

  typedef logic [DW-1:0] blk_t [N];

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid_in = 1'b0;
  logic          cmd_ready_out;
  logic          cmd_op_in = 1'b0;
  logic [DW-1:0] wr_data_in = '0;
  logic          wr_valid_in = 1'b0;
  logic          wr_ready_out;
  logic [DW-1:0] rd_data_out;
  logic          rd_valid_out;
  logic          rd_ready_in = 1'b0;
  logic          busy_out;
  logic          done_out;
  logic          sde_out;
  logic          sd_out;
  logic          filt_sd;
  logic          ul_out;
  logic          dl_out;

  int checks = 0;
  int failures = 0;

  filter_cfg_ctrl #(.DATABITS(DW), .NTAPS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_op_in(cmd_op_in),
    .wr_data_in(wr_data_in), .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in),
    .busy_out(busy_out), .done_out(done_out),
    .sde_out(sde_out), .sd_out(sd_out), .sd_in(filt_sd),
    .ul_out(ul_out), .dl_out(dl_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*DW-1:0] pack(input blk_t w);
    logic [N*DW-1:0] p;
    for (int i = 0; i < int'(N); i++) p[(N-1-i)*DW +: DW] = w[i];
    return p;
  endfunction

  // Filter model: one long shift chain, word 0 ends up at the top.
  blk_t            coef = '{default: '0};
  logic [N*DW-1:0] chain = '0;
  assign filt_sd = chain[N*DW-1];
  always @(posedge clk) begin
    if (ul_out)
      for (int i = 0; i < int'(N); i++) coef[i] <= chain[(N-1-i)*DW +: DW];
    if (dl_out) chain <= pack(coef);
    else if (sde_out) chain <= {chain[N*DW-2:0], sd_out};
  end

  // Monitor: event cycles, collected streams and protocol rule violations.
  int            acc_n = 0, acc_cyc = 0, ul_n = 0, ul_cyc = 0, dl_n = 0, dl_cyc = 0;
  int            done_n = 0, done_cyc = 0, fetch_n = 0, hold_n = 0, inv_err = 0;
  logic          sd_q [$];
  logic [DW-1:0] rd_q [$];
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (cmd_valid_in && cmd_ready_out) begin acc_n <= acc_n + 1; acc_cyc <= cyc + 1; end
    if (ul_out) begin ul_n <= ul_n + 1; ul_cyc <= cyc + 1; end
    if (dl_out) begin dl_n <= dl_n + 1; dl_cyc <= cyc + 1; end
    if (done_out) begin done_n <= done_n + 1; done_cyc <= cyc + 1; end
    if (wr_ready_out) fetch_n <= fetch_n + 1;
    if (rd_valid_out) hold_n <= hold_n + 1;
    if (sde_out) sd_q.push_back(sd_out);
    if (rd_valid_out && rd_ready_in) rd_q.push_back(rd_data_out);
    if ((!sde_out && sd_out) || (ul_out && dl_out) || ((ul_out || dl_out) && sde_out) ||
        (cmd_ready_out === busy_out) || (rd_valid_out && sde_out) || (wr_ready_out && sde_out) ||
        (rd_valid_out && prev_valid && (rd_data_out !== prev_data)))
      inv_err <= inv_err + 1;
    prev_valid <= rd_valid_out;
    prev_data  <= rd_data_out;
  end

  function automatic logic [N*DW-1:0] sd_pack(input int b);
    logic [N*DW-1:0] p;
    p = 'x;
    for (int k = 0; k < int'(N*DW); k++)
      if (b + k < sd_q.size()) p[N*DW-1-k] = sd_q[b+k];
    return p;
  endfunction

  function automatic logic [N*DW-1:0] rd_pack(input int b);
    logic [N*DW-1:0] p;
    p = 'x;
    for (int i = 0; i < int'(N); i++)
      if (b + i < rd_q.size()) p[(N-1-i)*DW +: DW] = rd_q[b+i];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 256'({cmd_ready_out, wr_ready_out, rd_valid_out, busy_out, done_out,
                             sde_out, sd_out, ul_out, dl_out}), 256'(9'b1_0000_0000));
    chk({tag, "_rdata"}, 256'(rd_data_out), 256'(0));
  endtask

  task automatic start_cmd(input logic op, output int t);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid_in = 1'b1;
    cmd_op_in    = op;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmd_ready_out) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    t = acc_cyc;
    chk("cmd_accept", 256'(ok), 256'(1));
    chk("busy_after_accept", 256'({busy_out, cmd_ready_out}), 256'(2'b10));
  endtask

  task automatic feed(input blk_t w, input int nw, input int gap_word);
    bit ok;
    for (int i = 0; i < nw; i++) begin
      ok = 1'b0;
      wr_data_in  = w[i];
      wr_valid_in = (i != gap_word);
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (wr_ready_out) begin ok = 1'b1; break; end
      end
      chk("wr_fetch_seen", 256'(ok), 256'(1));
      if (i == gap_word) begin
        repeat (5) @(posedge clk);
        #1 wr_valid_in = 1'b1;
      end
      @(posedge clk); #1;
    end
    wr_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (done_n >= target) break;
    end
    chk(tag, 256'(done_n >= target), 256'(1));
  endtask

  task automatic write_scn(input blk_t w, input int gap_word);
    int t, sb, f0, u0, d0, g, e;
    g  = (gap_word >= 0) ? 5 : 0;
    e  = 1 + int'(N * SL) + g;
    sb = sd_q.size(); f0 = fetch_n; u0 = ul_n; d0 = done_n;
    start_cmd(1'b0, t);
    feed(w, N, gap_word);
    wait_done(d0 + 1, "wr_done_seen");
    chk("wr_ul_count", 256'(ul_n - u0), 256'(1));
    chk("wr_ul_time", 256'(ul_cyc - t), 256'(e));
    chk("wr_done_time", 256'(done_cyc - t), 256'(e + 1));
    chk("wr_fetch_cycles", 256'(fetch_n - f0), 256'(int'(N) + g));
    chk("wr_stream_len", 256'(sd_q.size() - sb), 256'(N * DW));
    chk("wr_stream", 256'(sd_pack(sb)), 256'(pack(w)));
    chk("wr_filter_coef", 256'(pack(coef)), 256'(pack(w)));
    chk("wr_invariants", 256'(inv_err), 256'(0));
  endtask

  task automatic read_scn(input blk_t w, input int stall_word);
    int t, rb, h0, dl0, d0, s;
    bit ok;
    s  = (stall_word >= 0) ? 10 : 0;
    rb = rd_q.size(); h0 = hold_n; dl0 = dl_n; d0 = done_n;
    rd_ready_in = 1'b1;
    start_cmd(1'b1, t);
    if (stall_word >= 0) begin
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (rd_q.size() >= rb + stall_word) begin ok = 1'b1; break; end
        @(negedge clk); #1;
      end
      @(posedge clk); #1 rd_ready_in = 1'b0;
      for (int k = 0; k < 100 && !rd_valid_out; k++) @(negedge clk);
      chk("stall_hold_seen", 256'({ok, rd_valid_out}), 256'(2'b11));
      chk("stall_word_data", 256'(rd_data_out), 256'(w[stall_word]));
      repeat (s) @(posedge clk);
      #1;
      chk("stall_still_valid", 256'({rd_valid_out, sde_out}), 256'(2'b10));
      chk("stall_still_data", 256'(rd_data_out), 256'(w[stall_word]));
      rd_ready_in = 1'b1;
    end
    wait_done(d0 + 1, "rd_done_seen");
    chk("rd_dl_count", 256'(dl_n - dl0), 256'(1));
    chk("rd_dl_time", 256'(dl_cyc - t), 256'(1));
    chk("rd_done_time", 256'(done_cyc - t), 256'(2 + int'(N * SL) + s));
    chk("rd_hold_cycles", 256'(hold_n - h0), 256'(int'(N) + s));
    chk("rd_word_count", 256'(rd_q.size() - rb), 256'(N));
    chk("rd_words", 256'(rd_pack(rb)), 256'(pack(w)));
    chk("rd_invariants", 256'(inv_err), 256'(0));
  endtask

  blk_t w1, w2, w3;

  initial begin
    int t, t2, u0, d0, a0, rb;
    bit ok;
    w1[0] = 16'h8001;
    w1[1] = 16'h1234;
    for (int i = 2; i < int'(N); i++) w1[i] = DW'($urandom);
    for (int i = 0; i < int'(N); i++) begin
      w2[i] = DW'($urandom);
      w3[i] = DW'($urandom);
    end

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset during the shift of word 3 abandons the write
    start_cmd(1'b0, t);
    feed(w2, 4, -1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    u0 = ul_n; d0 = done_n;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (160) @(posedge clk);
    #1;
    chk("mid_rst_no_ul", 256'(ul_n - u0), 256'(0));
    chk("mid_rst_no_done", 256'(done_n - d0), 256'(0));
    chk("mid_rst_idle", 256'({cmd_ready_out, busy_out}), 256'(2'b10));

    // Full write, then the same block with a 5-cycle gap before word 4
    write_scn(w1, -1);
    write_scn(w1, 4);

    // Read back with host always ready
    read_scn(w1, -1);

    // Read command held high during a write: accepted in the first IDLE cycle
    d0 = done_n; a0 = acc_n; rb = rd_q.size();
    rd_ready_in = 1'b1;
    start_cmd(1'b0, t);
    cmd_valid_in = 1'b1;
    cmd_op_in    = 1'b1;
    feed(w3, N, -1);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (acc_n >= a0 + 2) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 cmd_valid_in = 1'b0;
    t2 = acc_cyc;
    chk("bb_second_accept", 256'(ok), 256'(1));
    chk("bb_write_done_first", 256'(done_n - d0), 256'(1));
    chk("bb_accept_after_done", 256'(t2 - done_cyc), 256'(1));
    chk("bb_write_ul_time", 256'(ul_cyc - t), 256'(1 + int'(N * SL)));
    wait_done(d0 + 2, "bb_read_done_seen");
    chk("bb_read_words", 256'(rd_pack(rb)), 256'(pack(w3)));
    chk("bb_filter_coef", 256'(pack(coef)), 256'(pack(w3)));
    chk("bb_invariants", 256'(inv_err), 256'(0));

    // Read with host stalling 10 cycles on word 2
    read_scn(w3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_cfg_ctrl.md
# filter_cfg_ctrl

Sequencer for the serial configuration port of `filter_unit`. It accepts block write and block read commands from a host on valid/ready interfaces. For a write it shifts NTAPS coefficient words MSB-first into the filter over `sde`/`sd`, then pulses upload. For a read it pulses download, shifts the NTAPS coefficient words back out of the filter and delivers them word by word to the host.

## Interface

Parameters:

- DATABITS, 16, coefficient word width; equals the `myfilter_pkg` value.
- NTAPS, 8, coefficient words per block transfer; at least 1.

Ports:

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid_in  in  1  host command valid.
- cmd_ready_out  out  1  high only in IDLE.
- cmd_op_in  in  1  0 = block write, 1 = block read; sampled only at command accept.
- wr_data_in  in  DATABITS  coefficient word to write.
- wr_valid_in  in  1  wr_data_in valid.
- wr_ready_out  out  1  high only in WR_FETCH.
- rd_data_out  out  DATABITS  coefficient word read back.
- rd_valid_out  out  1  rd_data_out valid; high only in RD_HOLD.
- rd_ready_in  in  1  host accepts rd_data_out.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse when a command completes.
- sde_out  out  1  serial enable; connects to filter `sde_in`.
- sd_out  out  1  serial data; connects to filter `sd_in`.
- sd_in  in  1  serial data returned by the filter; connects to filter `sd_out`.
- ul_out  out  1  upload pulse; connects to filter `ul_in`.
- dl_out  out  1  download pulse; connects to filter `dl_in`.

## Operation

FSM states: IDLE, WR_FETCH, WR_SHIFT, UL, DL, RD_SHIFT, RD_HOLD, DONE.

Counters and registers:
- bit_cnt, 0..DATABITS-1.
- word_cnt, 0..NTAPS-1.
- shift register, DATABITS bits.

Transitions:
- IDLE: on cmd_valid_in && cmd_ready_out, go to WR_FETCH if op=0, or to DL if op=1. Clear word_cnt.
- WR_FETCH: on wr_valid_in, load the word into the shift register, clear bit_cnt and go to WR_SHIFT. Otherwise stay; sde_out stays 0.
- WR_SHIFT: sde_out=1 and sd_out=shift register MSB. Shift left each cycle.
  - At bit_cnt=DATABITS-1: if word_cnt=NTAPS-1 go to UL; else increment word_cnt and go to WR_FETCH.
- UL: ul_out=1 for exactly one cycle, then go to DONE.
- DL: dl_out=1 for exactly one cycle, clear bit_cnt, then go to RD_SHIFT.
- RD_SHIFT: sde_out=1. sd_in is sampled at each rising edge into the shift register LSB, shifting left.
  - At bit_cnt=DATABITS-1, go to RD_HOLD; rd_data_out takes the completed word.
- RD_HOLD: rd_valid_out=1; serial shifting is paused (sde_out=0).
  - On rd_ready_in: if word_cnt=NTAPS-1 go to DONE; else increment word_cnt, clear bit_cnt and go to RD_SHIFT.
- DONE: done_out=1 for one cycle, then go to IDLE.

Output rules:
- sd_out is 0 whenever sde_out=0.
- ul_out and dl_out are never high in the same cycle.
- ul_out and dl_out are never high while sde_out=1.
- rd_data_out is stable while rd_valid_out=1.

## Timing

- Reset (asynchronous, any state): state goes to IDLE and counters and shift register clear.
  - All outputs are 0 except cmd_ready_out=1.
  - A transfer in progress is abandoned. No ul_out or dl_out pulse is issued and no done_out follows.
- Command accept is at edge T (cmd_valid_in && cmd_ready_out). busy_out is high from T+1.
- Write with wr_valid_in held high:
  - Each word takes 1 fetch cycle plus DATABITS shift cycles.
  - ul_out is high in cycle T+1+NTAPS*(DATABITS+1).
  - done_out is high in the following cycle.
- Read with rd_ready_in held high:
  - dl_out is high at T+1.
  - Each word takes DATABITS shift cycles plus 1 hold cycle.
  - done_out is high at T+2+NTAPS*(DATABITS+1).
- Stalls:
  - wr_valid_in low stretches WR_FETCH.
  - rd_ready_in low stretches RD_HOLD.
  - No serial bit is lost or duplicated across a stall.
- cmd_valid_in while busy_out=1 is ignored; cmd_ready_out is 0.
- A new command may be accepted in the cycle after DONE (IDLE).
- wr_valid_in outside WR_FETCH and rd_ready_in outside RD_HOLD have no effect.

## Test plan

- Reset mid-write: assert rst_n=0 during WR_SHIFT of word 3.
  - Required: all outputs drop immediately, cmd_ready_out=1, no ul_out pulse.
  - A following full write completes normally.
- Write, DATABITS=16, NTAPS=8, words 0x8001, 0x1234, … with wr_valid_in always high:
  - sd_out stream is 1000000000000001, then 0001001000110100, …
  - ul_out is high at T+137 and done_out at T+138.
  - The filter reference model holds all 8 words.
- Write with wr_valid_in dropped for 5 cycles before word 4:
  - sde_out=0 during the gap.
  - ul_out is delayed by exactly 5 cycles.
  - Bitstream is identical to the previous scenario.
- Read back after the write, rd_ready_in high:
  - dl_out pulses at T+1.
  - rd_data_out sequence is 0x8001, 0x1234, … on 8 rd_valid_out cycles.
  - done_out is high at T+138.
- Read with rd_ready_in low for 10 cycles on word 2:
  - rd_valid_out stays high and rd_data_out stays stable; sde_out=0 throughout.
  - Remaining words are correct.
  - done_out is delayed by 10 cycles.
- Back-to-back commands: cmd_valid_in held high with op=1 during a write.
  - Not accepted until IDLE.
  - Accepted in the first IDLE cycle after done_out.
